// File: rtl/trig_cond_pkg.sv
// Shared types and defaults for the trigger input conditioner.
package trig_cond_pkg;

  localparam int CNT_W_DEF   = 24;
  localparam int TIMER_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } trig_state_e;

  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic io_clk,
  input  logic io_rst_n,
  input  logic io_d,
  output logic io_q
);

  logic meta_r;
  logic sync_r;

  // two-stage capture of the raw pin
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= io_d;
      sync_r <= meta_r;
    end
  end

  assign io_q = sync_r;

endmodule

// File: rtl/trig_input_conditioner.sv
// Conditions one raw trigger pin: sync, invert, glitch filter, hold-off,
// one-cycle trigger pulse and wrapping accept/reject statistics.
module trig_input_conditioner
  import trig_cond_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic               io_clk,
  input  logic               io_rst_n,
  input  logic               io_in,
  input  logic               io_en,
  input  logic               io_invert,
  input  logic [CNT_W-1:0]   io_filt_len,
  input  logic [CNT_W-1:0]   io_holdoff_len,
  input  logic               io_cnt_clr,
  output logic               io_trig_pulse,
  output logic               io_level,
  output logic               io_busy,
  output logic [TIMER_W-1:0] io_accept_cnt,
  output logic [TIMER_W-1:0] io_reject_cnt
);

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TMR_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TMR_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic               sync_s;
  logic               s_s;
  logic               s_prev_r;
  logic [1:0]         warm_r;
  logic               rise_s;
  logic [CNT_W-1:0]   flen_s;
  logic               qual_done_s;
  trig_state_e        state_r;
  trig_state_e        next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               rej_inc_s;
  logic               pulse_next_s;
  logic               trig_pulse_r;
  logic [TIMER_W-1:0] accept_cnt_r;
  logic [TIMER_W-1:0] reject_cnt_r;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .io_clk   (io_clk),
    .io_rst_n (io_rst_n),
    .io_d     (io_in),
    .io_q     (sync_s)
  );

  assign s_s    = sync_s ^ io_invert;
  // warm_r keeps the reset-time zeros in the synchroniser from looking like an edge
  assign rise_s = (warm_r == 2'd3) && rise_edge(s_s, s_prev_r);
  assign flen_s = (io_filt_len == CNT_ZERO) ? CNT_ONE : io_filt_len;
  assign qual_done_s = ({1'b0, cnt_r} + {1'b0, CNT_ONE}) >= {1'b0, flen_s};

  // input history for edge detection
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      s_prev_r <= 1'b0;
      warm_r   <= 2'd0;
    end else begin
      s_prev_r <= s_s;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end
    end
  end

  // state register
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // next-state and counter update
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    rej_inc_s    = 1'b0;
    if (!io_en) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            if (flen_s == CNT_ONE) begin
              next_state_s = ACTIVE;
            end else begin
              cnt_next_s   = CNT_ONE;
              next_state_s = QUALIFY;
            end
          end else begin
            next_state_s = IDLE;
          end
        end
        QUALIFY: begin
          if (!s_s) begin
            rej_inc_s    = 1'b1;
            next_state_s = IDLE;
          end else if (qual_done_s) begin
            next_state_s = ACTIVE;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ACTIVE: begin
          if (s_s) begin
            next_state_s = ACTIVE;
          end else if (io_holdoff_len == CNT_ZERO) begin
            next_state_s = IDLE;
          end else begin
            cnt_next_s   = CNT_ONE;
            next_state_s = HOLDOFF;
          end
        end
        HOLDOFF: begin
          rej_inc_s = rise_edge(s_s, s_prev_r);
          if (cnt_r >= io_holdoff_len) begin
            next_state_s = IDLE;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // pulse on entry into ACTIVE; accept counts the same event
  always_comb begin
    pulse_next_s = (next_state_s == ACTIVE) && (state_r != ACTIVE);
  end

  // registered pulse and statistics; clear beats a same-cycle increment
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      trig_pulse_r <= 1'b0;
      accept_cnt_r <= TMR_ZERO;
      reject_cnt_r <= TMR_ZERO;
    end else begin
      trig_pulse_r <= pulse_next_s;
      if (io_cnt_clr) begin
        accept_cnt_r <= TMR_ZERO;
        reject_cnt_r <= TMR_ZERO;
      end else begin
        if (pulse_next_s) begin
          accept_cnt_r <= accept_cnt_r + TMR_ONE;
        end
        if (rej_inc_s) begin
          reject_cnt_r <= reject_cnt_r + TMR_ONE;
        end
      end
    end
  end

  assign io_trig_pulse = trig_pulse_r;
  assign io_level      = (state_r == ACTIVE);
  assign io_busy       = (state_r != IDLE);
  assign io_accept_cnt = accept_cnt_r;
  assign io_reject_cnt = reject_cnt_r;

endmodule

// File: tb/tb_trig_input_conditioner.sv
// Directed bench for trig_input_conditioner; statistics counters narrowed to 4 bits so wrap is reachable.
module tb_trig_input_conditioner;

  localparam int CW = 24;
  localparam int TW = 4;

  logic          io_clk = 1'b0;
  logic          io_rst_n;
  logic          io_in;
  logic          io_en;
  logic          io_invert;
  logic [CW-1:0] io_filt_len;
  logic [CW-1:0] io_holdoff_len;
  logic          io_cnt_clr;
  logic          io_trig_pulse;
  logic          io_level;
  logic          io_busy;
  logic [TW-1:0] io_accept_cnt;
  logic [TW-1:0] io_reject_cnt;

  int vectors    = 0;
  int miscompares = 0;

  trig_input_conditioner #(.CNT_W(CW), .TIMER_W(TW)) dut (
    .io_clk         (io_clk),
    .io_rst_n       (io_rst_n),
    .io_in          (io_in),
    .io_en          (io_en),
    .io_invert      (io_invert),
    .io_filt_len    (io_filt_len),
    .io_holdoff_len (io_holdoff_len),
    .io_cnt_clr     (io_cnt_clr),
    .io_trig_pulse  (io_trig_pulse),
    .io_level       (io_level),
    .io_busy        (io_busy),
    .io_accept_cnt  (io_accept_cnt),
    .io_reject_cnt  (io_reject_cnt)
  );

  always #50 io_clk = ~io_clk;

  // Drive pin = base ^ pat[k] before edge k, observe #1 after edge k.
  task automatic run_window(input int n, input logic base, input logic [63:0] pat, input int clr_at,
                            output int pulses, output int first_k, output int level_cyc,
                            output int busy_cyc, output int last_lvl);
    pulses = 0; first_k = -1; level_cyc = 0; busy_cyc = 0; last_lvl = -1;
    for (int k = 0; k < n; k++) begin
      io_in      = base ^ pat[k];
      io_cnt_clr = (k == clr_at);
      @(posedge io_clk); #1;
      if (io_trig_pulse) begin
        if (first_k < 0) first_k = k;
        pulses++;
      end
      if (io_level) begin
        level_cyc++;
        last_lvl = k;
      end
      if (io_busy) busy_cyc++;
    end
    io_cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    io_cnt_clr = 1'b1;
    @(posedge io_clk); #1;
    io_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    int p, f, l, b, ll;
    io_rst_n = 1'b1; io_in = 1'b0; io_en = 1'b1; io_invert = 1'b0;
    io_filt_len = 24'd1; io_holdoff_len = 24'd0; io_cnt_clr = 1'b0;
    #5 io_rst_n = 1'b0;
    #1;
    vectors++; if ({io_trig_pulse, io_level, io_busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {io_trig_pulse, io_level, io_busy}); end
    vectors++; if ({io_accept_cnt, io_reject_cnt} !== 8'h00) begin miscompares++; $display("FAIL reset_counts: got %h want 00", {io_accept_cnt, io_reject_cnt}); end
    @(posedge io_clk); @(posedge io_clk); #20 io_rst_n = 1'b1;
    run_window(4, 1'b0, 64'h0, -1, p, f, l, b, ll);
    // drive into ACTIVE and hold the pin high
    run_window(6, 1'b1, 64'h0, -1, p, f, l, b, ll);
    vectors++; if (f !== 2) begin miscompares++; $display("FAIL reset_pre_pulse_k: got %0d want 2", f); end
    vectors++; if (io_level !== 1'b1) begin miscompares++; $display("FAIL reset_pre_level: got %b want 1", io_level); end
    vectors++; if (io_accept_cnt !== 4'd1) begin miscompares++; $display("FAIL reset_pre_accept: got %0d want 1", io_accept_cnt); end
    #20 io_rst_n = 1'b0;
    #1;
    vectors++; if ({io_trig_pulse, io_level, io_busy} !== 3'b000) begin miscompares++; $display("FAIL reset_mid_flags: got %b want 000", {io_trig_pulse, io_level, io_busy}); end
    vectors++; if (io_accept_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_mid_accept: got %0d want 0", io_accept_cnt); end
    @(posedge io_clk); @(posedge io_clk); #20 io_rst_n = 1'b1;
    run_window(10, 1'b1, 64'h0, -1, p, f, l, b, ll);
    vectors++; if (p !== 0) begin miscompares++; $display("FAIL reset_held_high_pulses: got %0d want 0", p); end
    vectors++; if (b !== 0) begin miscompares++; $display("FAIL reset_held_high_busy: got %0d want 0", b); end
    run_window(4, 1'b0, 64'h0, -1, p, f, l, b, ll);
  endtask

  task automatic test_filter();
    int p, f, l, b, ll;
    io_filt_len = 24'd4; io_holdoff_len = 24'd0;
    clear_counters();
    run_window(16, 1'b0, 64'h3FF, -1, p, f, l, b, ll);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL filter_pulses: got %0d want 1", p); end
    vectors++; if (f !== 5) begin miscompares++; $display("FAIL filter_latency: got %0d want 5", f); end
    vectors++; if (l !== 7) begin miscompares++; $display("FAIL filter_level_cycles: got %0d want 7", l); end
    vectors++; if (ll !== 11) begin miscompares++; $display("FAIL filter_level_last: got %0d want 11", ll); end
    vectors++; if (b !== 10) begin miscompares++; $display("FAIL filter_busy_cycles: got %0d want 10", b); end
    vectors++; if (io_accept_cnt !== 4'd1) begin miscompares++; $display("FAIL filter_accept: got %0d want 1", io_accept_cnt); end
  endtask

  task automatic test_glitch();
    int p, f, l, b, ll;
    io_filt_len = 24'd4; io_holdoff_len = 24'd0;
    clear_counters();
    run_window(10, 1'b0, 64'h7, -1, p, f, l, b, ll);
    vectors++; if (p !== 0) begin miscompares++; $display("FAIL glitch_pulses: got %0d want 0", p); end
    vectors++; if (b !== 3) begin miscompares++; $display("FAIL glitch_busy_cycles: got %0d want 3", b); end
    vectors++; if (io_reject_cnt !== 4'd1) begin miscompares++; $display("FAIL glitch_reject: got %0d want 1", io_reject_cnt); end
    vectors++; if (io_accept_cnt !== 4'd0) begin miscompares++; $display("FAIL glitch_accept: got %0d want 0", io_accept_cnt); end
  endtask

  task automatic test_holdoff();
    int p, f, l, b, ll;
    io_filt_len = 24'd1; io_holdoff_len = 24'd8;
    clear_counters();
    run_window(40, 1'b0, 64'h0000_0000_0030_0033, -1, p, f, l, b, ll);
    vectors++; if (p !== 2) begin miscompares++; $display("FAIL holdoff_pulses: got %0d want 2", p); end
    vectors++; if (f !== 2) begin miscompares++; $display("FAIL holdoff_first_k: got %0d want 2", f); end
    vectors++; if (b !== 20) begin miscompares++; $display("FAIL holdoff_busy_cycles: got %0d want 20", b); end
    vectors++; if (io_accept_cnt !== 4'd2) begin miscompares++; $display("FAIL holdoff_accept: got %0d want 2", io_accept_cnt); end
    vectors++; if (io_reject_cnt !== 4'd1) begin miscompares++; $display("FAIL holdoff_reject: got %0d want 1", io_reject_cnt); end
  endtask

  task automatic test_invert();
    int p, f, l, b, ll;
    io_filt_len = 24'd2; io_holdoff_len = 24'd0;
    io_en = 1'b0; io_invert = 1'b1;
    run_window(4, 1'b1, 64'h0, -1, p, f, l, b, ll);
    io_en = 1'b1;
    run_window(12, 1'b1, 64'h1F, -1, p, f, l, b, ll);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL invert_pulses: got %0d want 1", p); end
    vectors++; if (f !== 3) begin miscompares++; $display("FAIL invert_latency: got %0d want 3", f); end
    vectors++; if (l !== 4) begin miscompares++; $display("FAIL invert_level_cycles: got %0d want 4", l); end
    io_en = 1'b0; io_invert = 1'b0;
    run_window(4, 1'b1, 64'h0, -1, p, f, l, b, ll);
    io_en = 1'b1;
    run_window(14, 1'b1, 64'h1F, -1, p, f, l, b, ll);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL noinv_pulses: got %0d want 1", p); end
    vectors++; if (f !== 8) begin miscompares++; $display("FAIL noinv_trailing_edge_k: got %0d want 8", f); end
    vectors++; if (io_level !== 1'b1) begin miscompares++; $display("FAIL noinv_level_held: got %b want 1", io_level); end
    io_en = 1'b0;
    run_window(1, 1'b1, 64'h0, -1, p, f, l, b, ll);
    vectors++; if ({io_level, io_busy} !== 2'b00) begin miscompares++; $display("FAIL disable_drop: got %b want 00", {io_level, io_busy}); end
    run_window(4, 1'b0, 64'h0, -1, p, f, l, b, ll);
    io_en = 1'b1;
  endtask

  task automatic test_wrap();
    int p, f, l, b, ll;
    int total;
    io_filt_len = 24'd1; io_holdoff_len = 24'd0;
    clear_counters();
    total = 0;
    for (int t = 0; t < 15; t++) begin
      run_window(6, 1'b0, 64'h3, -1, p, f, l, b, ll);
      total += p;
    end
    vectors++; if (total !== 15) begin miscompares++; $display("FAIL wrap_total_pulses: got %0d want 15", total); end
    vectors++; if (io_accept_cnt !== 4'hF) begin miscompares++; $display("FAIL wrap_preload: got %h want f", io_accept_cnt); end
    run_window(6, 1'b0, 64'h3, -1, p, f, l, b, ll);
    vectors++; if (io_accept_cnt !== 4'h0) begin miscompares++; $display("FAIL wrap_rollover: got %h want 0", io_accept_cnt); end
    run_window(6, 1'b0, 64'h3, -1, p, f, l, b, ll);
    vectors++; if (io_accept_cnt !== 4'h1) begin miscompares++; $display("FAIL wrap_after_roll: got %h want 1", io_accept_cnt); end
    // clear lands on the very edge that would increment accept
    run_window(6, 1'b0, 64'h3, 2, p, f, l, b, ll);
    vectors++; if (f !== 2) begin miscompares++; $display("FAIL clr_pulse_k: got %0d want 2", f); end
    vectors++; if (io_accept_cnt !== 4'h0) begin miscompares++; $display("FAIL clr_beats_inc: got %h want 0", io_accept_cnt); end
    run_window(6, 1'b0, 64'h3, -1, p, f, l, b, ll);
    vectors++; if (io_accept_cnt !== 4'h1) begin miscompares++; $display("FAIL clr_then_inc: got %h want 1", io_accept_cnt); end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_glitch();
    test_holdoff();
    test_invert();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_input_conditioner.md
Name: trig_input_conditioner

Overview:
Conditions one raw trigger-drive or feedback pin before the 10 MHz synchronous-trigger logic.
- Synchronises the pin and applies optional polarity inversion.
- Rejects glitches shorter than a programmable width and enforces a programmable hold-off (dead time) after each accepted trigger.
- Emits a one-cycle trigger pulse plus a filtered level, and keeps wrapping accept/reject counters for bus readback.
- The top instantiates one per pin (io_trigDriv and each io_fbPort bit).

Parameters:
CNT_W, 24, width of filter-length and hold-off-length counters
TIMER_W, 32, width of accept/reject statistics counters

Ports:
io_clk  in  1  logic clock (10 MHz domain); single clock
io_rst_n  in  1  reset, asynchronous, active-low
io_in  in  1  raw asynchronous pin
io_en  in  1  conditioner enable (quasi-static, io_clk domain)
io_invert  in  1  1 = pin is active-low
io_filt_len  in  CNT_W  minimum qualifying high width in cycles (0 treated as 1)
io_holdoff_len  in  CNT_W  dead time in cycles after release (0 = none)
io_cnt_clr  in  1  synchronous clear of both statistics counters
io_trig_pulse  out  1  one-cycle pulse per accepted trigger
io_level  out  1  filtered level, high while state ACTIVE
io_busy  out  1  high in QUALIFY, ACTIVE or HOLDOFF
io_accept_cnt  out  TIMER_W  accepted triggers, wraps
io_reject_cnt  out  TIMER_W  rejected glitches plus hold-off hits, wraps

Behaviour:
- Reset (io_rst_n low, async): sync flops 0, s_prev 0, state IDLE, cnt 0, all outputs 0.
- Input path: 2-flop synchroniser, then s = sync2 ^ io_invert; s_prev = s delayed one cycle. All FSM decisions use registered s.
- State encoding: IDLE=0, QUALIFY=1, ACTIVE=2, HOLDOFF=3. flen = max(io_filt_len,1). Config is sampled live every cycle.
- IDLE:
  - Arms only on a rising edge (s=1 and s_prev=0). An input held high out of reset or hold-off never triggers.
  - On edge: if flen==1, go to ACTIVE; else cnt<=1 and go to QUALIFY.
- QUALIFY:
  - If s=0: reject_cnt++ and go to IDLE.
  - Else if cnt+1>=flen: go to ACTIVE.
  - Else cnt++.
  - The s=0 check takes priority.
- ACTIVE:
  - On the entry cycle: io_trig_pulse=1 (registered, exactly one cycle) and accept_cnt++.
  - Stay while s=1.
  - On s=0: if io_holdoff_len==0, go to IDLE; else cnt<=1 and go to HOLDOFF.
- HOLDOFF:
  - Input is ignored for triggering; each s rising edge seen here increments reject_cnt.
  - If cnt>=io_holdoff_len, go to IDLE; else cnt++.
- Latency: clean edge with the pin steady before clock edge 0 -> io_trig_pulse high in the cycle after edge 1+flen (2+flen−1 FSM cycles after sync).
- io_en=0: FSM forced to IDLE next cycle; no pulse and no counter increments. An ongoing ACTIVE is dropped (io_level falls). The synchroniser keeps running.
- Counters:
  - Wrap from all-ones to 0.
  - io_cnt_clr beats a same-cycle increment: the result is 0, and the event is lost.
  - Accept and reject can never increment in the same cycle.
- Outputs: io_level=(state==ACTIVE) and io_busy=(state!=IDLE), both registered-state decodes with no combinational path from io_in.

Decomposition:
- Package trig_cond_pkg: state enum/localparams (IDLE, QUALIFY, ACTIVE, HOLDOFF), default widths CNT_W=24 and TIMER_W=32.
- Sub-module sync_2ff (parameterisable reset value 0) for the input synchroniser; it is reused for the other async pins at top level.

Test Plan:
1. Reset mid-ACTIVE (io_rst_n low between clock edges) -> all outputs 0 immediately, state IDLE; after release, an input already held high gives no pulse.
2. filt_len=4, holdoff=0, io_in high for 10 cycles -> exactly one io_trig_pulse, 5 edges after the input edge; io_level high until 2 cycles after io_in falls; accept_cnt=1.
3. filt_len=4, io_in high 3 cycles then low -> no pulse, reject_cnt=1, io_busy high for 3 cycles.
4. filt_len=1, holdoff=8, two 2-cycle pulses 4 cycles apart -> first accepted, second counted reject; accept=1, reject=1; a third pulse after hold-off is accepted (accept=2).
5. io_invert=1, io_in idle high, 5-cycle low pulse, filt_len=2 -> one pulse; with io_invert=0, the same stimulus triggers on the trailing rising edge instead.
6. Preload accept_cnt to 0xFFFFFFFF via repeated triggers (or force), one more trigger -> 0; io_cnt_clr asserted on the same cycle as an accept -> counter reads 0.
